fake_differential_delay_ctrl: RTL

FAKE_DIFFERENTIAL_DELAY_CTRL -- requirements
Module: fake_differential_delay_ctrl

---
 rtl/fake_differential_delay_ctrl.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/fake_differential_delay_ctrl.sv
// DELAYF tap controller: walks one lane's delay tap to an absolute target with MOVE strobes,
// or reloads every lane to tap 0 through LOADN. One request in flight; req_ready only in IDLE.
module fake_differential_delay_ctrl #(
  parameter int MOVE_HI     = 2,
  parameter int MOVE_LO     = 2,
  parameter int LOAD_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_lane,
  input  logic [6:0] req_tap,
  input  logic       clear,
  output logic [3:0] move,
  output logic       dir,
  output logic       loadn,
  output logic [6:0] tap0,
  output logic [6:0] tap1,
  output logic [6:0] tap2,
  output logic [6:0] tap3,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    S_LOAD, S_IDLE, S_SETUP, S_PULSE_HI, S_PULSE_LO, S_FINISH
  } state_t;

  localparam logic [3:0] LOAD_LAST = 4'(LOAD_CYCLES - 1);
  localparam logic [3:0] HI_LAST   = 4'(MOVE_HI - 1);
  localparam logic [3:0] LO_LAST   = 4'(MOVE_LO - 1);

  state_t     r_state;
  logic [3:0] r_cnt;
  logic [3:0] r_move;
  logic       r_dir;
  logic       r_loadn;
  logic       r_done;
  logic [1:0] r_lane;
  logic [6:0] r_target;
  logic       r_nop;
  logic [6:0] r_tap [4];

  assign req_ready = (r_state == S_IDLE) && !clear;
  assign busy      = (r_state != S_IDLE);
  assign move      = r_move;
  assign dir       = r_dir;
  assign loadn     = r_loadn;
  assign done      = r_done;
  assign tap0      = r_tap[0];
  assign tap1      = r_tap[1];
  assign tap2      = r_tap[2];
  assign tap3      = r_tap[3];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_LOAD;
      r_cnt    <= '0;
      r_move   <= '0;
      r_dir    <= 1'b0;
      r_loadn  <= 1'b0;
      r_done   <= 1'b0;
      r_lane   <= '0;
      r_target <= '0;
      r_nop    <= 1'b0;
      r_tap    <= '{default: '0};
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_LOAD: begin
          r_loadn <= 1'b0;
          r_move  <= '0;
          if (r_cnt == LOAD_LAST) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_loadn <= 1'b1;
            r_done  <= 1'b1;
            r_tap   <= '{default: '0};
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_IDLE: begin
          if (clear) begin
            r_state <= S_LOAD;
            r_cnt   <= '0;
            r_loadn <= 1'b0;
          end else if (req_valid) begin
            r_lane   <= req_lane;
            r_target <= req_tap;
            if (req_tap == r_tap[req_lane]) begin
              r_state <= S_FINISH;
              r_nop   <= 1'b1;
            end else begin
              r_state <= S_SETUP;
              r_nop   <= 1'b0;
              r_dir   <= (req_tap < r_tap[req_lane]);
            end
          end
        end
        S_SETUP: begin
          r_state <= S_PULSE_HI;
          r_cnt   <= '0;
          r_move  <= 4'b0001 << r_lane;
        end
        S_PULSE_HI: begin
          if (r_cnt == HI_LAST) begin
            r_state       <= S_PULSE_LO;
            r_cnt         <= '0;
            r_move        <= '0;
            r_tap[r_lane] <= r_dir ? r_tap[r_lane] - 7'd1 : r_tap[r_lane] + 7'd1;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_PULSE_LO: begin
          if (r_cnt == LO_LAST) begin
            r_cnt <= '0;
            if (r_tap[r_lane] == r_target) begin
              r_state <= S_FINISH;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_PULSE_HI;
              r_move  <= 4'b0001 << r_lane;
            end
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_FINISH: begin
          // A no-move request reports done one cycle later so both paths share the 2-cycle overhead.
          r_state <= S_IDLE;
          if (r_nop) r_done <= 1'b1;
        end
        default: r_state <= S_LOAD;
      endcase
    end
  end

endmodule
